m_wb_periphctrl: RTL and testbench

//  Wishbone peripheral-bus controller between the midgetv core master port and the

---
 rtl/m_wb_pkg.sv | 19 +
 rtl/m_wb_watchdog.sv | 38 +++
 rtl/m_wb_periphctrl.sv | 144 ++++++++++++++
 tb/tb_m_wb_periphctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/m_wb_pkg.sv
// Shared definitions for the midgetv Wishbone peripheral controller:
// FSM state encoding, error-flag bit positions and the watchdog counter width.
package m_wb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int unsigned NERR   = 3;
    localparam int unsigned DECERR = 0;
    localparam int unsigned TMO    = 1;
    localparam int unsigned STRAY  = 2;

    // Enough bits to hold TIMEOUT itself, so the counter can never wrap.
    function automatic int unsigned cnt_width(input int unsigned tmo);
        return $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/m_wb_watchdog.sv
// Bus-timeout watchdog: loadable up-counter with a terminal-count flag that
// fires when the counter has reached TIMEOUT-1.
module m_wb_watchdog
    import m_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic CLK_I,
    input  logic nRST_I,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int unsigned CW = cnt_width(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/m_wb_periphctrl.sv
// Wishbone peripheral-bus controller: one-hot slave decode, registered strobes,
// read-data capture, timeout watchdog and sticky error flags.
module m_wb_periphctrl
    import m_wb_pkg::*;
#(
    parameter int unsigned NSLV    = 3,
    parameter int unsigned ADRBIT0 = 2,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                   CLK_I,
    input  logic                   nRST_I,
    input  logic                   STB_I,
    input  logic [31:0]            ADR_I,
    output logic                   ACK_O,
    output logic [DWIDTH-1:0]      DAT_O,
    output logic [NSLV-1:0]        s_STB_O,
    input  logic [NSLV-1:0]        s_ACK_I,
    input  logic [NSLV*DWIDTH-1:0] s_DAT_I,
    input  logic                   errclr,
    output logic [NERR-1:0]        errflags
);

    logic [1:0]        state_q, state_d;
    logic [NSLV-1:0]   stb_q, stb_d;
    logic              ack_q, ack_d;
    logic [DWIDTH-1:0] dat_q, dat_d;
    logic [NERR-1:0]   err_q, err_d;

    logic [NSLV-1:0]   sel;
    logic              sel_onehot;
    logic [DWIDTH-1:0] rd_mux;
    logic              slv_hit;
    logic              wd_clr, wd_inc, wd_tc;
    logic              decerr_set, tmo_set, stray_set;
    logic [NERR-1:0]   err_set;
    logic              unused_adr;

    assign sel        = ADR_I[ADRBIT0 +: NSLV];
    assign sel_onehot = ($countones(sel) == 1);
    assign unused_adr = ^ADR_I;

    assign slv_hit   = |(s_ACK_I & stb_q);
    assign stray_set = |(s_ACK_I & ~stb_q);

    // AND-OR read mux; stb_q is one-hot or zero, so no priority is needed.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < int'(NSLV); i++) begin
            rd_mux = rd_mux | ({DWIDTH{stb_q[i]}} & s_DAT_I[i*DWIDTH +: DWIDTH]);
        end
    end

    always_comb begin
        state_d    = state_q;
        stb_d      = stb_q;
        ack_d      = 1'b0;
        dat_d      = dat_q;
        wd_clr     = 1'b0;
        wd_inc     = 1'b0;
        decerr_set = 1'b0;
        tmo_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (STB_I) begin
                    if (sel_onehot) begin
                        stb_d   = sel;
                        wd_clr  = 1'b1;
                        state_d = BUSY;
                    end else begin
                        ack_d      = 1'b1;
                        dat_d      = '0;
                        decerr_set = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            BUSY: begin
                wd_inc = 1'b1;
                // A slave ACK in the terminal-count cycle takes precedence.
                if (slv_hit) begin
                    dat_d   = rd_mux;
                    ack_d   = 1'b1;
                    stb_d   = '0;
                    state_d = DONE;
                end else if (wd_tc) begin
                    dat_d   = '0;
                    ack_d   = 1'b1;
                    stb_d   = '0;
                    tmo_set = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                stb_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        err_set         = '0;
        err_set[DECERR] = decerr_set;
        err_set[TMO]    = tmo_set;
        err_set[STRAY]  = stray_set;
        // Set events override a simultaneous clear.
        err_d = (errclr ? '0 : err_q) | err_set;
    end

    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            state_q <= IDLE;
            stb_q   <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
        end
    end

    m_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK_I  (CLK_I),
        .nRST_I (nRST_I),
        .clr_i  (wd_clr),
        .inc_i  (wd_inc),
        .tc_o   (wd_tc)
    );

    assign ACK_O    = ack_q;
    assign DAT_O    = dat_q;
    assign s_STB_O  = stb_q;
    assign errflags = err_q;

endmodule

// File: tb/tb_m_wb_periphctrl.sv
// Directed self-checking bench for m_wb_periphctrl with default parameters.
module tb_m_wb_periphctrl;

    logic        CLK_I = 1'b0;
    logic        nRST_I;
    logic        STB_I;
    logic [31:0] ADR_I;
    logic        ACK_O;
    logic [31:0] DAT_O;
    logic [2:0]  s_STB_O;
    logic [2:0]  s_ACK_I;
    logic [95:0] s_DAT_I;
    logic        errclr;
    logic [2:0]  errflags;

    int checks   = 0;
    int failures = 0;

    m_wb_periphctrl dut (
        .CLK_I    (CLK_I),
        .nRST_I   (nRST_I),
        .STB_I    (STB_I),
        .ADR_I    (ADR_I),
        .ACK_O    (ACK_O),
        .DAT_O    (DAT_O),
        .s_STB_O  (s_STB_O),
        .s_ACK_I  (s_ACK_I),
        .s_DAT_I  (s_DAT_I),
        .errclr   (errclr),
        .errflags (errflags)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        nRST_I  = 1'b0;
        STB_I   = 1'b0;
        ADR_I   = '0;
        s_ACK_I = '0;
        errclr  = 1'b0;
        s_DAT_I = {32'h5555_FFFF, 32'h0000_1234, 32'hAAAA_0000};
        #3;
        chk("rst_ack", 32'(ACK_O), 32'd0);
        chk("rst_dat", DAT_O, 32'd0);
        chk("rst_stb", 32'(s_STB_O), 32'd0);
        chk("rst_err", 32'(errflags), 32'd0);
        step();
        step();
        nRST_I = 1'b1;
        step();

        // 1: read slave1, ACK two cycles after strobe
        STB_I = 1'b1;
        ADR_I = 32'h8;
        step();
        chk("t1_stb_c1", 32'(s_STB_O), 32'h2);
        chk("t1_ack_c1", 32'(ACK_O), 32'd0);
        step();
        chk("t1_stb_c2", 32'(s_STB_O), 32'h2);
        s_ACK_I = 3'b010;
        step();
        chk("t1_ack_c3", 32'(ACK_O), 32'd1);
        chk("t1_dat_c3", DAT_O, 32'h0000_1234);
        chk("t1_stb_c3", 32'(s_STB_O), 32'd0);
        s_ACK_I = '0;
        STB_I   = 1'b0;
        step();
        chk("t1_ack_c4", 32'(ACK_O), 32'd0);
        chk("t1_dat_hold", DAT_O, 32'h0000_1234);
        chk("t1_err", 32'(errflags), 32'd0);

        // 2: unmapped then multi-hot address
        STB_I = 1'b1;
        ADR_I = 32'h0;
        step();
        chk("t2a_ack", 32'(ACK_O), 32'd1);
        chk("t2a_dat", DAT_O, 32'd0);
        chk("t2a_stb", 32'(s_STB_O), 32'd0);
        chk("t2a_err", 32'(errflags), 32'h1);
        STB_I = 1'b0;
        step();
        chk("t2_idle_ack", 32'(ACK_O), 32'd0);
        STB_I = 1'b1;
        ADR_I = 32'h1C;
        step();
        chk("t2b_ack", 32'(ACK_O), 32'd1);
        chk("t2b_dat", DAT_O, 32'd0);
        chk("t2b_stb", 32'(s_STB_O), 32'd0);
        chk("t2b_err", 32'(errflags), 32'h1);
        STB_I = 1'b0;
        step();
        errclr = 1'b1;
        step();
        errclr = 1'b0;
        chk("t2_clr", 32'(errflags), 32'd0);

        // 3: slave0 never ACKs -> timeout
        STB_I = 1'b1;
        ADR_I = 32'h4;
        step();
        for (int c = 1; c <= 15; c++) begin
            chk($sformatf("t3_stb_c%0d", c), 32'(s_STB_O), 32'h1);
            chk($sformatf("t3_ack_c%0d", c), 32'(ACK_O), 32'd0);
            step();
        end
        chk("t3_ack_c16", 32'(ACK_O), 32'd1);
        chk("t3_dat_c16", DAT_O, 32'd0);
        chk("t3_stb_c16", 32'(s_STB_O), 32'd0);
        chk("t3_err", 32'(errflags), 32'h2);
        STB_I = 1'b0;
        step();
        chk("t3_ack_c17", 32'(ACK_O), 32'd0);
        errclr = 1'b1;
        step();
        errclr = 1'b0;
        chk("t3_clr", 32'(errflags), 32'd0);

        // 4a: slave2 ACKs exactly in the timeout cycle
        STB_I = 1'b1;
        ADR_I = 32'h10;
        step();
        for (int c = 1; c <= 14; c++) begin
            step();
        end
        chk("t4a_stb_c15", 32'(s_STB_O), 32'h4);
        chk("t4a_ack_c15", 32'(ACK_O), 32'd0);
        s_ACK_I = 3'b100;
        step();
        chk("t4a_ack_c16", 32'(ACK_O), 32'd1);
        chk("t4a_dat_c16", DAT_O, 32'h5555_FFFF);
        chk("t4a_err", 32'(errflags), 32'd0);
        s_ACK_I = '0;
        STB_I   = 1'b0;
        step();

        // 4b: late slave0 ACK after a timeout -> stray flag only
        STB_I = 1'b1;
        ADR_I = 32'h4;
        for (int c = 0; c <= 15; c++) begin
            step();
        end
        chk("t4b_ack_c16", 32'(ACK_O), 32'd1);
        chk("t4b_err_tmo", 32'(errflags), 32'h2);
        STB_I   = 1'b0;
        s_ACK_I = 3'b001;
        step();
        chk("t4b_err_stray", 32'(errflags), 32'h6);
        chk("t4b_ack_c17", 32'(ACK_O), 32'd0);
        s_ACK_I = '0;
        step();
        chk("t4b_ack_c18", 32'(ACK_O), 32'd0);
        chk("t4b_stb_c18", 32'(s_STB_O), 32'd0);

        // 5: errclr together with a decode error, then errclr alone
        STB_I  = 1'b1;
        ADR_I  = 32'h0;
        errclr = 1'b1;
        step();
        STB_I  = 1'b0;
        errclr = 1'b0;
        chk("t5_err_set_wins", 32'(errflags), 32'h1);
        chk("t5_ack", 32'(ACK_O), 32'd1);
        step();
        errclr = 1'b1;
        step();
        errclr = 1'b0;
        chk("t5_err_clr", 32'(errflags), 32'd0);

        // 6: reset while BUSY, then a normal access
        STB_I = 1'b1;
        ADR_I = 32'h8;
        step();
        chk("t6_stb_busy", 32'(s_STB_O), 32'h2);
        step();
        #2;
        nRST_I = 1'b0;
        STB_I  = 1'b0;
        #1;
        chk("t6_rst_stb", 32'(s_STB_O), 32'd0);
        chk("t6_rst_ack", 32'(ACK_O), 32'd0);
        step();
        #2;
        nRST_I = 1'b1;
        step();
        s_DAT_I[63:32] = 32'h0000_CAFE;
        STB_I = 1'b1;
        ADR_I = 32'h8;
        step();
        chk("t6_stb_c1", 32'(s_STB_O), 32'h2);
        s_ACK_I = 3'b010;
        step();
        chk("t6_ack_c2", 32'(ACK_O), 32'd1);
        chk("t6_dat_c2", DAT_O, 32'h0000_CAFE);
        chk("t6_err", 32'(errflags), 32'd0);
        s_ACK_I = '0;
        STB_I   = 1'b0;
        step();
        chk("t6_ack_c3", 32'(ACK_O), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
